// File: rtl/onehot_checker.sv
// onehot_checker
//
// Watches a free-running ring counter and reports whether it is advancing
// correctly. Every rising edge the onehot input is sampled; a sample is valid
// when exactly one bit is set, and a correct advance is the previous sample
// rotated left by one (bit WIDTH-1 wraps to bit 0). After LOCK_COUNT correct
// advances in a row the checker locks. Any deviation while locked pulses err
// and bumps a saturating error counter.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous active-high reset, overrides every other input
//   onehot       ring-counter value under test, sampled each edge
//   err_clr      synchronous clear of err_count
//   index        binary position of the set bit in the last valid sample
//   index_valid  last sample was exactly one-hot
//   locked       checker is in LOCKED
//   err          one-cycle pulse on a sequence error while locked
//   err_count    saturating (255) count of errors
//
// All outputs are registered and describe the sample taken at the previous edge.
//
// state   | meaning
// --------+-------------------------------------------------------------
// SEARCH  | no usable reference sample yet; waiting for a valid one
// TRACK   | have a valid reference, counting consecutive correct advances
// LOCKED  | LOCK_COUNT advances seen; any deviation is an error

module onehot_checker #(
    parameter int WIDTH      = 8,
    parameter int LOCK_COUNT = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         onehot,
    input  logic                     err_clr,
    output logic [$clog2(WIDTH)-1:0] index,
    output logic                     index_valid,
    output logic                     locked,
    output logic                     err,
    output logic [7:0]               err_count
);

    localparam int         IDX_W    = $clog2(WIDTH);
    localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       run_q, run_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic             index_valid_q, index_valid_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic [7:0]       err_count_q, err_count_d;

    logic             sample_valid;
    logic             sample_match;
    logic [IDX_W-1:0] set_pos;
    logic [WIDTH-1:0] expected;

    // Sample classification and the position of its (single) set bit.
    always_comb begin
        sample_valid = (onehot != '0) && ((onehot & (onehot - 1'b1)) == '0);
        expected     = {prev_q[WIDTH-2:0], prev_q[WIDTH-1]};
        // prev_q is only ever consulted from TRACK/LOCKED, where it was valid,
        // so a match implies the sample itself is valid. A hold never matches.
        sample_match = (onehot == expected);
        set_pos      = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (onehot[i]) begin
                set_pos = IDX_W'(i);
            end
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d       = state_q;
        run_d         = run_q;
        err_d         = 1'b0;
        prev_d        = onehot;
        index_d       = sample_valid ? set_pos : index_q;
        index_valid_d = sample_valid;

        case (state_q)
            ST_SEARCH: begin
                if (sample_valid) begin
                    state_d = ST_TRACK;
                    run_d   = '0;
                end
            end
            ST_TRACK: begin
                if (sample_match) begin
                    if (run_q + 4'd1 == LOCK_CNT) begin
                        state_d = ST_LOCKED;
                        run_d   = LOCK_CNT;
                    end else begin
                        run_d = run_q + 4'd1;
                    end
                end else if (sample_valid) begin
                    // Restart the run with this sample as the new reference.
                    run_d = '0;
                end else begin
                    state_d = ST_SEARCH;
                    run_d   = '0;
                end
            end
            ST_LOCKED: begin
                if (!sample_match) begin
                    err_d   = 1'b1;
                    run_d   = '0;
                    state_d = sample_valid ? ST_TRACK : ST_SEARCH;
                end
            end
            default: begin
                state_d = ST_SEARCH;
                run_d   = '0;
            end
        endcase

        locked_d = (state_d == ST_LOCKED);

        // A clear coinciding with an error leaves that error counted.
        if (err_clr) begin
            err_count_d = {7'd0, err_d};
        end else if (err_d && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end else begin
            err_count_d = err_count_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // The sample present during reset is dropped, not kept as reference.
            state_q       <= ST_SEARCH;
            run_q         <= '0;
            prev_q        <= '0;
            index_q       <= '0;
            index_valid_q <= 1'b0;
            locked_q      <= 1'b0;
            err_q         <= 1'b0;
            err_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            run_q         <= run_d;
            prev_q        <= prev_d;
            index_q       <= index_d;
            index_valid_q <= index_valid_d;
            locked_q      <= locked_d;
            err_q         <= err_d;
            err_count_q   <= err_count_d;
        end
    end

    assign index       = index_q;
    assign index_valid = index_valid_q;
    assign locked      = locked_q;
    assign err         = err_q;
    assign err_count   = err_count_q;

endmodule

// File: tb/tb_onehot_checker.sv
module tb_onehot_checker;

    localparam int WIDTH      = 8;
    localparam int LOCK_COUNT = 4;
    localparam int IW         = $clog2(WIDTH);

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] onehot;
    logic             err_clr;
    logic [IW-1:0]    index;
    logic             index_valid;
    logic             locked;
    logic             err;
    logic [7:0]       err_count;

    int checks = 0;
    int passes = 0;

    onehot_checker #(.WIDTH(WIDTH), .LOCK_COUNT(LOCK_COUNT)) dut (
        .clk         (clk),
        .reset       (reset),
        .onehot      (onehot),
        .err_clr     (err_clr),
        .index       (index),
        .index_valid (index_valid),
        .locked      (locked),
        .err         (err),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    // Reference model: tracks whether we have a reference sample, how many
    // consecutive correct advances have been seen, and whether we are locked.
    logic [WIDTH-1:0] m_prev;
    bit               m_have_ref;
    bit               m_locked;
    int               m_streak;
    int               m_index;
    bit               m_iv;
    bit               m_err;
    int               m_cnt;

    function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] v);
        return (v << 1) | (v >> (WIDTH - 1));
    endfunction

    task automatic model_step(input logic [WIDTH-1:0] s, input bit rst, input bit clr);
        bit valid;
        bit adv;
        if (rst) begin
            m_prev = '0; m_have_ref = 0; m_locked = 0; m_streak = 0;
            m_index = 0; m_iv = 0; m_err = 0; m_cnt = 0;
            return;
        end
        valid = ($countones(s) == 1);
        adv   = (m_have_ref || m_locked) && (s == rotl(m_prev));
        m_err = 0;
        if (valid) m_index = $clog2(s);
        m_iv = valid;
        if (m_locked) begin
            if (!adv) begin
                m_err = 1; m_locked = 0; m_have_ref = valid; m_streak = 0;
            end
        end else if (m_have_ref) begin
            if (!valid) begin
                m_have_ref = 0;
            end else if (adv) begin
                m_streak++;
                if (m_streak == LOCK_COUNT) begin
                    m_locked = 1; m_have_ref = 0;
                end
            end else begin
                m_streak = 0;
            end
        end else if (valid) begin
            m_have_ref = 1; m_streak = 0;
        end
        if (clr) m_cnt = m_err ? 1 : 0;
        else if (m_err && m_cnt < 255) m_cnt++;
        m_prev = s;
    endtask

    // Apply one sample for one edge, advance the model, settle past the edge.
    task automatic cycle(input logic [WIDTH-1:0] s, input bit rst, input bit clr);
        onehot  = s;
        reset   = rst;
        err_clr = clr;
        @(posedge clk);
        model_step(s, rst, clr);
        #1;
        reset   = 1'b0;
        err_clr = 1'b0;
    endtask

    // Reset then walk 0x01..0x10: locked afterwards with the ring at 0x10.
    task automatic lock_up();
        cycle(8'h00, 1, 0);
        for (int i = 0; i < 5; i++) cycle(8'h01 << i, 0, 0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(8'h01, 1, 0);
            checks++;
            if ({index, index_valid, locked, err, err_count} !== '0)
                $display("FAIL reset_outputs cyc=%0d got idx=%0d iv=%0b lk=%0b err=%0b cnt=%0d want all 0",
                         i, index, index_valid, locked, err, err_count);
            else passes++;
        end
        // Start at 0x02: reaches lock only after 0x20 if starting from SEARCH.
        for (int i = 1; i < 6; i++) begin
            cycle(8'h01 << i, 0, 0);
            checks++;
            if (index !== IW'(i) || index_valid !== 1'b1 || locked !== (i == 5) || err !== 1'b0)
                $display("FAIL post_reset_start step=%0d got idx=%0d iv=%0b lk=%0b err=%0b want idx=%0d iv=1 lk=%0b err=0",
                         i, index, index_valid, locked, err, i, (i == 5));
            else passes++;
        end
    endtask

    task automatic test_lock_ramp();
        cycle(8'h00, 1, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(8'h01 << i, 0, 0);
            checks++;
            if (index !== IW'(i) || index_valid !== 1'b1 || locked !== (i == 4) || err !== 1'b0)
                $display("FAIL lock_ramp step=%0d got idx=%0d iv=%0b lk=%0b err=%0b want idx=%0d iv=1 lk=%0b err=0",
                         i, index, index_valid, locked, err, i, (i == 4));
            else passes++;
        end
    endtask

    task automatic test_wrap();
        logic [WIDTH-1:0] seq [4];
        int               exp_idx [4];
        seq = '{8'h20, 8'h40, 8'h80, 8'h01};
        exp_idx = '{5, 6, 7, 0};
        lock_up();
        for (int i = 0; i < 4; i++) begin
            cycle(seq[i], 0, 0);
            checks++;
            if (index !== IW'(exp_idx[i]) || locked !== 1'b1 || err !== 1'b0 || err_count !== 8'd0)
                $display("FAIL wrap step=%0d got idx=%0d lk=%0b err=%0b cnt=%0d want idx=%0d lk=1 err=0 cnt=0",
                         i, index, locked, err, err_count, exp_idx[i]);
            else passes++;
        end
    endtask

    task automatic test_skip_error();
        lock_up();
        cycle(8'h40, 0, 0);
        checks++;
        if (err !== 1'b1 || err_count !== 8'd1 || locked !== 1'b0 || index !== 3'd6)
            $display("FAIL skip_err got err=%0b cnt=%0d lk=%0b idx=%0d want err=1 cnt=1 lk=0 idx=6",
                     err, err_count, locked, index);
        else passes++;
        cycle(8'h80, 0, 0);
        checks++;
        if (err !== 1'b0 || locked !== 1'b0)
            $display("FAIL skip_err_pulse got err=%0b lk=%0b want err=0 lk=0", err, locked);
        else passes++;
        cycle(8'h01, 0, 0);
        cycle(8'h02, 0, 0);
        checks++;
        if (locked !== 1'b0)
            $display("FAIL skip_relock_early got lk=%0b want 0", locked);
        else passes++;
        cycle(8'h04, 0, 0);
        checks++;
        if (locked !== 1'b1 || err_count !== 8'd1)
            $display("FAIL skip_relock got lk=%0b cnt=%0d want lk=1 cnt=1", locked, err_count);
        else passes++;
    endtask

    task automatic test_invalid();
        logic [WIDTH-1:0] bad [3];
        bad = '{8'h03, 8'h00, 8'h10};   // multi-bit, zero, hold
        for (int k = 0; k < 3; k++) begin
            lock_up();
            cycle(bad[k], 0, 0);
            checks++;
            if (index_valid !== (k == 2) || index !== 3'd4 || err !== 1'b1 || locked !== 1'b0 || err_count !== 8'd1)
                $display("FAIL invalid_err case=%0d got iv=%0b idx=%0d err=%0b lk=%0b cnt=%0d want iv=%0b idx=4 err=1 lk=0 cnt=1",
                         k, index_valid, index, err, locked, err_count, (k == 2));
            else passes++;
            for (int i = 0; i < 5; i++) begin
                cycle(8'h01 << i, 0, 0);
                checks++;
                if (index !== IW'(i) || index_valid !== 1'b1 || err !== 1'b0 || locked !== (i == 4))
                    $display("FAIL invalid_recover case=%0d step=%0d got idx=%0d iv=%0b err=%0b lk=%0b want idx=%0d iv=1 err=0 lk=%0b",
                             k, i, index, index_valid, err, locked, i, (i == 4));
                else passes++;
            end
        end
    endtask

    task automatic test_saturate_and_clear();
        logic [WIDTH-1:0] cur;
        lock_up();
        cur = 8'h10;
        for (int n = 0; n < 300; n++) begin
            cycle(cur, 0, 0);                   // hold -> error
            checks++;
            if (err !== 1'b1 || err_count !== 8'(m_cnt))
                $display("FAIL sat_err n=%0d got err=%0b cnt=%0d want err=1 cnt=%0d", n, err, err_count, m_cnt);
            else passes++;
            for (int i = 0; i < LOCK_COUNT; i++) begin
                cur = rotl(cur);
                cycle(cur, 0, 0);
            end
        end
        checks++;
        if (err_count !== 8'd255 || locked !== 1'b1)
            $display("FAIL sat_final got cnt=%0d lk=%0b want cnt=255 lk=1", err_count, locked);
        else passes++;
        cur = rotl(cur);
        cycle(cur, 0, 1);
        checks++;
        if (err_count !== 8'd0 || locked !== 1'b1)
            $display("FAIL clr_alone got cnt=%0d lk=%0b want cnt=0 lk=1", err_count, locked);
        else passes++;
        for (int i = 0; i < 3; i++) cycle(cur, 0, 0);   // rack up some errors
        for (int i = 0; i < 6; i++) begin
            cur = rotl(cur);
            cycle(cur, 0, 0);
        end
        cycle(cur, 0, 1);                       // hold + clear together
        checks++;
        if (err_count !== 8'd1 || err !== 1'b1)
            $display("FAIL clr_with_err got cnt=%0d err=%0b want cnt=1 err=1", err_count, err);
        else passes++;
        for (int i = 0; i < 5; i++) begin
            cur = rotl(cur);
            cycle(cur, 0, 0);
        end
        cycle(cur, 1, 1);                       // reset beats clear and error
        checks++;
        if (err_count !== 8'd0 || locked !== 1'b0 || err !== 1'b0 || index_valid !== 1'b0 || index !== '0)
            $display("FAIL reset_locked got cnt=%0d lk=%0b err=%0b iv=%0b idx=%0d want all 0",
                     err_count, locked, err, index_valid, index);
        else passes++;
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] last;
        logic [WIDTH-1:0] s;
        bit               rst;
        bit               clr;
        last = 8'h01;
        for (int n = 0; n < 4000; n++) begin
            case ($urandom_range(0, 11))
                0, 1, 2, 3, 4, 5, 6: s = rotl(last);
                7:       s = 8'h01 << $urandom_range(0, WIDTH - 1);
                8:       s = 8'($urandom);
                9:       s = 8'h00;
                10:      s = last;
                default: s = 8'h01 << $urandom_range(0, WIDTH - 1) | 8'h01 << $urandom_range(0, WIDTH - 1);
            endcase
            if (s == 8'h00 && $urandom_range(0, 1) == 1) s = 8'h01;
            rst = ($urandom_range(0, 299) == 0);
            clr = ($urandom_range(0, 24) == 0);
            cycle(s, rst, clr);
            if (!rst) last = s;
            checks++;
            if ({index, index_valid, locked, err, err_count} !== {m_index[IW-1:0], m_iv, m_locked, m_err, m_cnt[7:0]})
                $display("FAIL random n=%0d s=%h got idx=%0d iv=%0b lk=%0b err=%0b cnt=%0d want idx=%0d iv=%0b lk=%0b err=%0b cnt=%0d",
                         n, s, index, index_valid, locked, err, err_count,
                         m_index, m_iv, m_locked, m_err, m_cnt);
            else passes++;
        end
    endtask

    initial begin
        reset   = 1'b1;
        onehot  = '0;
        err_clr = 1'b0;
        #2;
        test_reset();
        test_lock_ramp();
        test_wrap();
        test_skip_error();
        test_invalid();
        test_saturate_and_clear();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/onehot_checker.md
ONEHOT_CHECKER -- requirements
Module: onehot_checker

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the ring width in bits (WIDTH >= 2).
REQ-002 The block SHALL have parameter LOCK_COUNT, default 4, giving the number of consecutive correct advances needed to lock (1..15).
REQ-003 The block SHALL have port clk, input, 1 bit, the single rising-edge clock.
REQ-004 The block SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-005 The block SHALL have port onehot, input, WIDTH bits, the ring-counter value, sampled every rising edge.
REQ-006 The block SHALL have port err_clr, input, 1 bit, a synchronous clear of err_count.
REQ-007 The block SHALL have port index, output, clog2(WIDTH) bits, the binary position of the set bit in the last valid sample.
REQ-008 The block SHALL have port index_valid, output, 1 bit, high when the last sample was exactly one-hot.
REQ-009 The block SHALL have port locked, output, 1 bit, high while in state LOCKED.
REQ-010 The block SHALL have port err, output, 1 bit, a one-cycle pulse on a sequence error while locked.
REQ-011 The block SHALL have port err_count, output, 8 bits, a saturating count of errors.

Function
REQ-012 valid sample SHALL be defined as exactly one bit of onehot set; all-zero and multi-bit values are invalid.
REQ-013 expected SHALL be defined as the previous sample rotated left by one, with bit WIDTH-1 wrapping to bit 0.
REQ-014 All outputs SHALL be registered, reflecting the sample taken at the preceding rising edge (1-cycle latency).
REQ-015 On a valid sample, index SHALL load the set-bit position and index_valid SHALL go to 1.
REQ-016 On an invalid sample, index_valid SHALL go to 0 and index SHALL hold its value.
REQ-017 The block SHALL implement states SEARCH, TRACK and LOCKED, with an internal run counter that saturates at LOCK_COUNT.
REQ-018 SEARCH: a valid sample SHALL go to TRACK with run=0; an invalid sample SHALL stay in SEARCH.
REQ-019 TRACK: a sample equal to expected SHALL set run=run+1, and the state SHALL go to LOCKED when run+1 equals LOCK_COUNT.
REQ-020 TRACK: a valid sample not equal to expected SHALL stay in TRACK with run=0 (restart from that sample).
REQ-021 TRACK: an invalid sample SHALL go to SEARCH.
REQ-022 LOCKED: a sample equal to expected SHALL stay in LOCKED.
REQ-023 LOCKED: any other sample SHALL assert err for one cycle and increment err_count, then go to TRACK with run=0 if the sample is valid, otherwise to SEARCH.
REQ-024 err SHALL never assert outside LOCKED, and mismatches in SEARCH or TRACK SHALL NOT count.
REQ-025 locked SHALL rise the cycle after the edge that completes LOCK_COUNT advances, and SHALL fall the cycle after the error edge.
REQ-026 err_count SHALL saturate at 255 and never wrap.
REQ-027 err_clr alone SHALL set err_count to 0; err_clr together with an error in the same cycle SHALL set err_count to 1.
REQ-028 A hold (sample equal to previous sample) SHALL be treated as a mismatch.
REQ-029 The wrap from bit WIDTH-1 to bit 0 SHALL be a correct advance.

Reset
REQ-030 reset SHALL take priority over all other inputs, including err_clr and an error in the same cycle.
REQ-031 On reset the block SHALL set state=SEARCH, run=0, index=0, index_valid=0, locked=0, err=0 and err_count=0.
REQ-032 The onehot value sampled during reset SHALL be discarded and SHALL NOT be used as the previous sample.
REQ-033 Reset asserted mid-lock SHALL clear err_count and drop locked on the next edge.

Verification
REQ-034 Bench SHALL cover: reset held 3 cycles with onehot=0x01 -> all outputs 0; the first post-reset sample starts from SEARCH.
REQ-035 Bench SHALL cover: 0x01,0x02,0x04,0x08,0x10 on consecutive edges -> index 0,1,2,3,4 with index_valid=1; locked=1 after the 5th edge; err=0.
REQ-036 Bench SHALL cover: while locked, 0x40,0x80,0x01 -> index 6,7,0; locked stays 1; no err (wrap correct).
REQ-037 Bench SHALL cover: locked at 0x10 then 0x40 -> err pulse 1 cycle, err_count=1, locked=0; then 0x80,0x01,0x02,0x04 -> locked=1 again.
REQ-038 Bench SHALL cover: locked then 0x03, and locked then 0x00 -> index_valid=0, index holds, err pulse, state SEARCH; a following 0x01 enters TRACK.
REQ-039 Bench SHALL cover: 300 lock/error cycles -> err_count=255; err_clr coincident with an error -> 1; reset while locked -> err_count=0, locked=0.
